ssd_scan_driver: RTL and testbench

- Parametrised multiplexed seven-segment display driver; successor to the fixed 8-digit ssd used on the Nexys A7 debug builds.
- Scans N_DIGITS hex digits with active-low anodes and cathodes.
- Adds atomic frame-synchronous value update, per-digit decimal points, leading-zero blanking, PWM brightness and a frame-start strobe.
- Sits at the board top level, fed by Manta probe/memory signals or user logic.

---
 rtl/ssd_pkg.sv | 20 ++
 rtl/ssd_hex_decode.sv | 11 +
 rtl/ssd_scan_driver.sv | 144 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package ssd_pkg;

  // All segments off (active-low), used for reset and blanked digits.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Pick nibble idx out of a packed vector of up to 16 nibbles.
  function automatic logic [3:0] nibble_sel(input logic [63:0] vec, input logic [3:0] idx);
    return vec[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_FONT[i_nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous value update,
// per-digit decimal points, leading-zero blanking and PWM brightness.
//
// Value handshake: val_valid_in is a one-cycle strobe with no back-pressure;
// val_in is taken on every cycle the strobe is high. Strobes between frame
// boundaries collapse into one pending value (last wins); the displayed
// shadow only changes at the frame boundary, and frame_out pulses the cycle
// after it changes.
module ssd_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int SLOT_CYCLES = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [4*N_DIGITS-1:0] val_in,
  input  logic                  val_valid_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz_in,
  input  logic [BRIGHT_W-1:0]   bright_in,
  output logic [6:0]            cat_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_out
);

  import ssd_pkg::*;

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  // Wide enough for (2**BRIGHT_W) * SLOT_CYCLES without overflow.
  localparam int PROD_W = BRIGHT_W + 1 + $clog2(SLOT_CYCLES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [DIG_W-1:0]      r_digit_idx;
  logic [4*N_DIGITS-1:0] r_pending;
  logic                  r_pending_vld;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [6:0]            r_cat;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame;

  logic                  w_slot_wrap;
  logic                  w_boundary;
  logic [PROD_W-1:0]     w_on_thresh;
  logic                  w_enable;
  logic [N_DIGITS-1:0]   w_zero_from;
  logic                  w_run;
  logic                  w_blank;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_an_sel;

  assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
  assign w_boundary  = w_slot_wrap && (r_digit_idx == DIG_LAST);

  // Anode is lit for the first on_thresh cycles of each slot; all-ones
  // brightness yields on_thresh == SLOT_CYCLES, i.e. always lit.
  assign w_on_thresh = ((PROD_W'(bright_in) + PROD_W'(1)) * PROD_W'(SLOT_CYCLES)) >> BRIGHT_W;
  assign w_enable    = (PROD_W'(r_slot_cnt) < w_on_thresh);

  // w_zero_from[i] is set when shadow nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    w_run       = 1'b1;
    w_zero_from = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run & (r_shadow[i*4 +: 4] == 4'h0);
      w_zero_from[i] = w_run;
    end
  end

  // Digit 0 always shows something, even for an all-zero value.
  assign w_blank  = blank_lz_in && (r_digit_idx != '0) && w_zero_from[r_digit_idx];
  assign w_nibble = nibble_sel(64'(r_shadow), 4'(r_digit_idx));
  assign w_an_sel = ~(N_DIGITS'(1) << r_digit_idx);

  ssd_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Slot and digit counters that pace the scan.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  // Capture strobes into pending and commit to shadow on the frame boundary.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_pending     <= '0;
      r_pending_vld <= 1'b0;
      r_shadow      <= '0;
      r_frame       <= 1'b0;
    end else if (w_boundary) begin
      r_pending_vld <= 1'b0;
      if (val_valid_in) begin
        r_shadow <= val_in;
        r_frame  <= 1'b1;
      end else if (r_pending_vld) begin
        r_shadow <= r_pending;
        r_frame  <= 1'b1;
      end else begin
        r_frame  <= 1'b0;
      end
    end else begin
      r_frame <= 1'b0;
      if (val_valid_in) begin
        r_pending     <= val_in;
        r_pending_vld <= 1'b1;
      end
    end
  end

  // Registered display outputs derived from the current scan position.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_an  <= '1;
      r_cat <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_enable ? w_an_sel : '1;
      r_cat <= w_blank ? SEG_BLANK : w_seg;
      r_dp  <= w_enable ? ~dp_in[r_digit_idx] : 1'b1;
    end
  end

  assign cat_out   = r_cat;
  assign dp_out    = r_dp;
  assign an_out    = r_an;
  assign frame_out = r_frame;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (4 digits, 4-cycle slots, 2-bit
// brightness): a cycle-level reference model plus hand-computed spot checks.
module tb_ssd_scan_driver;

  localparam int ND   = 4;
  localparam int SLOT = 4;
  localparam int BW   = 2;
  localparam int FRM  = ND * SLOT;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [15:0]   val_in;
  logic          val_valid_in;
  logic [3:0]    dp_in;
  logic          blank_lz_in;
  logic [BW-1:0] bright_in;
  logic [6:0]    cat_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_out;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  int          m_t = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend = '0;
  logic        m_pend_v = 1'b0;
  logic        m_started = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_cat = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_frame = 1'b0;
  int          md, ms, mthr;
  logic        mon;
  logic [15:0] mupper;

  ssd_scan_driver #(
    .N_DIGITS    (ND),
    .SLOT_CYCLES (SLOT),
    .BRIGHT_W    (BW)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .val_in       (val_in),
    .val_valid_in (val_valid_in),
    .dp_in        (dp_in),
    .blank_lz_in  (blank_lz_in),
    .bright_in    (bright_in),
    .cat_out      (cat_out),
    .dp_out       (dp_out),
    .an_out       (an_out),
    .frame_out    (frame_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is m_t cycles since reset release.
  initial begin
    forever begin
      @(posedge clk_in);
      if (!rst_n_in) begin
        m_t = 0; m_shadow = '0; m_pend_v = 1'b0; m_started = 1'b1;
        e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
      end else begin
        md     = (m_t / SLOT) % ND;
        ms     = m_t % SLOT;
        mthr   = ((int'(bright_in) + 1) * SLOT) / (2 ** BW);
        mon    = (ms < mthr);
        mupper = m_shadow >> (4 * md);
        e_cat  = (blank_lz_in && md > 0 && mupper == 16'h0) ? 7'h7F : FONT[mupper[3:0]];
        e_an   = mon ? ~(4'b0001 << md) : 4'hF;
        e_dp   = mon ? ~dp_in[md] : 1'b1;
        if ((m_t % FRM) == FRM - 1) begin
          e_frame = 1'b0;
          if (val_valid_in) begin
            m_shadow = val_in; e_frame = 1'b1;
          end else if (m_pend_v) begin
            m_shadow = m_pend; e_frame = 1'b1;
          end
          m_pend_v = 1'b0;
        end else begin
          e_frame = 1'b0;
          if (val_valid_in) begin
            m_pend = val_in; m_pend_v = 1'b1;
          end
        end
        m_t++;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk_in) begin
    if (m_started) begin
      check("an_model",    32'(an_out),    32'(e_an));
      check("cat_model",   32'(cat_out),   32'(e_cat));
      check("dp_model",    32'(dp_out),    32'(e_dp));
      check("frame_model", 32'(frame_out), 32'(e_frame));
    end
  end

  // Driver tasks
  task automatic strobe(input logic [15:0] v);
    val_in = v; val_valid_in = 1'b1;
    @(negedge clk_in);
    val_valid_in = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while ((m_t % FRM) != pos && k < 2 * FRM) begin
      @(negedge clk_in); k++;
    end
    if ((m_t % FRM) != pos) check("wait_pos_timeout", 32'(m_t % FRM), 32'(pos));
  endtask

  task automatic wait_an(input string name, input logic [3:0] an, input logic [6:0] cat);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * FRM && !found; k++) begin
      @(negedge clk_in);
      if (an_out == an) found = 1'b1;
    end
    if (found) check(name, 32'(cat_out), 32'(cat));
    else       check({name, "_an_timeout"}, 32'(an_out), 32'(an));
  endtask

  task automatic wait_frame(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * FRM && !found; k++) begin
      @(negedge clk_in);
      if (frame_out) found = 1'b1;
    end
    check({name, "_frame_seen"}, 32'(found), 32'd1);
  endtask

  task automatic count_frames(input string name, input int cycles, input int exp);
    int c;
    c = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_in);
      if (frame_out) c++;
    end
    check(name, 32'(c), 32'(exp));
  endtask

  task automatic count_on(input string name, input int exp);
    int c;
    c = 0;
    for (int k = 0; k < FRM; k++) begin
      @(negedge clk_in);
      if (an_out != 4'hF) c++;
    end
    check(name, 32'(c), 32'(exp));
  endtask

  // Directed sequence
  initial begin
    int dp_lo, dp_bad;
    rst_n_in = 1'b0; val_in = '0; val_valid_in = 1'b0; dp_in = '0;
    blank_lz_in = 1'b0; bright_in = 2'd3;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    // First cycle after release: still at reset values
    check("rst_an",    32'(an_out),    32'hF);
    check("rst_cat",   32'(cat_out),   32'h7F);
    check("rst_dp",    32'(dp_out),    32'h1);
    check("rst_frame", 32'(frame_out), 32'h0);
    @(negedge clk_in);
    check("first_an",  32'(an_out),  32'hE);
    check("first_cat", 32'(cat_out), 32'h40);
    repeat (4) @(negedge clk_in);
    check("scan_an_d", 32'(an_out), 32'hD);
    repeat (4) @(negedge clk_in);
    check("scan_an_b", 32'(an_out), 32'hB);
    repeat (4) @(negedge clk_in);
    check("scan_an_7", 32'(an_out), 32'h7);
    count_frames("idle_no_frame", 2 * FRM, 0);

    // Mid-frame strobe of 12AF
    wait_pos(6);
    strobe(16'h12AF);
    count_frames("12af_one_frame", 20, 1);
    wait_an("12af_d0", 4'hE, 7'h0E);
    wait_an("12af_d1", 4'hD, 7'h08);
    wait_an("12af_d2", 4'hB, 7'h24);
    wait_an("12af_d3", 4'h7, 7'h79);

    // Last strobe wins; boundary-coincident strobe bypasses pending
    wait_pos(2);
    strobe(16'h1111);
    wait_pos(8);
    strobe(16'h2222);
    wait_pos(FRM - 1);
    strobe(16'h3333);
    wait_an("3333_d0", 4'hE, 7'h30);
    wait_an("3333_d3", 4'h7, 7'h30);

    // Leading-zero blanking
    blank_lz_in = 1'b1;
    strobe(16'h0005);
    wait_frame("lz5");
    wait_an("lz5_d0", 4'hE, 7'h12);
    wait_an("lz5_d1", 4'hD, 7'h7F);
    wait_an("lz5_d2", 4'hB, 7'h7F);
    wait_an("lz5_d3", 4'h7, 7'h7F);
    strobe(16'h0000);
    wait_frame("lz0");
    wait_an("lz0_d0", 4'hE, 7'h40);
    wait_an("lz0_d1", 4'hD, 7'h7F);

    // Brightness duty over a full frame
    bright_in = 2'd0;
    count_on("bright0_on", 4);
    bright_in = 2'd1;
    count_on("bright1_on", 8);
    bright_in = 2'd3;
    count_on("bright3_on", 16);

    // Decimal point on digit 2 only, gated by PWM
    bright_in = 2'd1;
    dp_in = 4'b0100;
    dp_lo = 0; dp_bad = 0;
    for (int k = 0; k < FRM; k++) begin
      @(negedge clk_in);
      if (!dp_out) begin
        dp_lo++;
        if (an_out != 4'hB) dp_bad++;
      end
    end
    check("dp_low_count", 32'(dp_lo), 32'd2);
    check("dp_wrong_digit", 32'(dp_bad), 32'd0);
    dp_in = 4'b0000;
    bright_in = 2'd3;
    blank_lz_in = 1'b0;

    // Reset mid-frame with a pending value
    wait_pos(5);
    strobe(16'h4444);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check("midrst_an",    32'(an_out),    32'hF);
    check("midrst_cat",   32'(cat_out),   32'h7F);
    check("midrst_dp",    32'(dp_out),    32'h1);
    check("midrst_frame", 32'(frame_out), 32'h0);
    rst_n_in = 1'b1;
    count_frames("midrst_no_frame", 3 * FRM, 0);
    wait_an("midrst_d0", 4'hE, 7'h40);
    wait_an("midrst_d2", 4'hB, 7'h40);

    repeat (4) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
